mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one single-ported unified memory between the pipeline's instruction-fetch port and its data-memory (MEM stage) port. It arbitrates, issues one outstanding transaction at a time over a ready/valid memory handshake, and routes responses back to the owning requester. It drives grant and stall information so the hazard logic can freeze the PC and pipeline registers. Data accesses have priority over fetches.

Parameters:
ADDR_W, 32, address width of both requester ports and the memory port.
DATA_W, 32, data width; byte strobe width is DATA_W/8.
STARVE_MAX, 4, consecutive data grants tolerated while a fetch waits (used only with the optional feature).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous reset, active-low (0 = reset, sampled on the rising edge of clk).
if_req  in  1  fetch request; held stable until if_gnt.
if_addr  in  ADDR_W  fetch address.
if_flush  in  1  discard any outstanding fetch response.
if_gnt  out  1  fetch accepted by memory this cycle.
if_rvalid  out  1  fetch data valid, one-cycle pulse.
if_rdata  out  DATA_W  fetch data.
if_stall  out  1  if_req & ~if_gnt.
dm_req  in  1  data request; held stable until dm_gnt.
dm_we  in  1  1 = store, 0 = load.
dm_wstrb  in  DATA_W/8  store byte enables.
dm_addr  in  ADDR_W  data address.
dm_wdata  in  DATA_W  store data.
dm_gnt  out  1  data request accepted this cycle.
dm_rvalid  out  1  load data or store acknowledge, one-cycle pulse.
dm_rdata  out  DATA_W  load data; 0 for stores.
dm_stall  out  1  dm_req & ~(transaction complete).
mem_req  out  1  memory request.
mem_we  out  1  memory write.
mem_addr  out  ADDR_W  memory address.
mem_wdata  out  DATA_W  memory write data.
mem_wstrb  out  DATA_W/8  memory byte enables; 0 on fetches.
mem_ready  in  1  memory accepts the request this cycle.
mem_rvalid  in  1  memory response: read data or write acknowledge.
mem_rdata  in  DATA_W  memory read data.

Behaviour:
- FSM states: IDLE, BUSY_IF, BUSY_DM. Reset value is IDLE.
- IDLE:
  - Select dm if dm_req; otherwise select if if if_req.
  - mem_req and the selected source's fields are driven combinationally.
  - Handshake completes on mem_req & mem_ready. In that cycle the owner's gnt pulses and the FSM moves to BUSY_DM or BUSY_IF.
  - Without mem_ready, stay in IDLE and re-arbitrate next cycle. A dm_req that appears later preempts a fetch that has not yet been granted.
- BUSY_x: mem_req = 0; no new grant. On mem_rvalid, capture mem_rdata and return to IDLE.
- Responses are registered: x_rvalid and x_rdata are asserted the cycle after mem_rvalid.
  - Minimum access: gnt at t, mem_rvalid at t+1, x_rvalid at t+2.
  - Next grant no earlier than the mem_rvalid cycle + 1.
- dm_stall stays 1 from dm_req assertion through the mem_rvalid cycle and falls with dm_rvalid. Store: dm_rdata = 0.
- Flush:
  - A fetch_killed flag is set when if_flush is seen in BUSY_IF, or in IDLE in the same cycle as the fetch grant.
  - When the response arrives, if_rvalid is suppressed. The FSM still returns to IDLE on mem_rvalid, and the flag clears then.
  - if_flush coincident with mem_rvalid also suppresses the response.
  - if_flush in IDLE with no fetch grant has no effect.
- mem_rvalid in IDLE (spurious) is ignored.
- Reset mid-transaction: FSM goes to IDLE, the killed flag clears, all registered outputs go to 0, and any in-flight response is dropped.
- Reset value of all outputs is 0: if_rvalid, dm_rvalid, if_rdata, dm_rdata are registered; every combinational output evaluates to 0 while in reset.

Optional Feature:
MEM_ARB_STARVE_GUARD_EN
- Defined: a counter increments on each dm grant while if_req = 1, and clears on an if grant or when if_req = 0. When the count equals STARVE_MAX, arbitration in IDLE selects the fetch even if dm_req is asserted.
- Undefined: strict data priority; no counter logic; STARVE_MAX unused.

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum typedef (IDLE, BUSY_IF, BUSY_DM);
  - the owner encoding (OWN_IF, OWN_DM);
  - the counter width constant, $clog2(STARVE_MAX+1).
- One sub-module, mem_arb_starve_ctr, implements the starvation counter and is instantiated only under MEM_ARB_STARVE_GUARD_EN.

Test Plan:
- Reset: rst = 0 for 2 cycles with if_req = 1 → mem_req = 0, all outputs 0. After release, fetch at 0x0000_0010 granted the first cycle mem_ready = 1.
- Fetch: if_addr = 0x0000_0020, memory latency 1, mem_rdata = 0x0010_0093 → if_gnt at t, if_rvalid = 1 with if_rdata = 0x0010_0093 at t+2.
- Contention: if_req and dm_req (load 0x0000_0100) rise together → dm granted first; if_gnt follows one cycle after dm's mem_rvalid; if_stall = 1 throughout.
- Store: dm_we = 1, wstrb = 4'b0011, wdata = 0xDEAD_BEEF → mem_wstrb = 4'b0011; dm_rvalid pulses with dm_rdata = 0; dm_stall falls the same cycle.
- Flush: if_flush pulses in BUSY_IF → no if_rvalid; the next fetch is granted normally; if_flush coincident with mem_rvalid is also suppressed.
- With MEM_ARB_STARVE_GUARD_EN and STARVE_MAX = 4: continuous dm_req plus if_req → after 4 dm grants, the 5th grant goes to the fetch and the counter clears. Without the macro, the fetch is never granted.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and sizing helpers for the fetch/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_IF,
        BUSY_DM
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } arb_owner_e;

    localparam int unsigned STARVE_MAX_DEFAULT = 4;
    localparam int unsigned STARVE_CTR_W       = $clog2(STARVE_MAX_DEFAULT + 1);

    // Counter width able to hold 0..max_count inclusive.
    function automatic int unsigned starve_ctr_width(input int unsigned max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Counts data grants taken while a fetch is waiting; flags when the fetch must win.
module mem_arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic dm_grant,
    input  logic if_grant,
    input  logic if_req,
    output logic starved
);

    localparam int unsigned CTR_W = starve_ctr_width(STARVE_MAX);

    logic [CTR_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (if_grant || !if_req) begin
            count <= '0;
        end else if (dm_grant && (count != CTR_W'(STARVE_MAX))) begin
            count <= count + CTR_W'(1);
        end
    end

    assign starved = (count == CTR_W'(STARVE_MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-ported memory arbiter between instruction fetch and data access (data has priority).
// Build option MEM_ARB_STARVE_GUARD_EN bounds how many data grants a waiting fetch tolerates.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    input  logic                  if_flush,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_W-1:0]     if_rdata,
    output logic                  if_stall,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [DATA_W/8-1:0]   dm_wstrb,
    input  logic [ADDR_W-1:0]     dm_addr,
    input  logic [DATA_W-1:0]     dm_wdata,
    output logic                  dm_gnt,
    output logic                  dm_rvalid,
    output logic [DATA_W-1:0]     dm_rdata,
    output logic                  dm_stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    input  logic [DATA_W-1:0]     mem_rdata
);

    if (STARVE_MAX < 1) begin : g_bad_starve_max
        $error("STARVE_MAX must be at least 1");
    end

    arb_state_e state, state_next;
    arb_owner_e sel;
    logic       killed, killed_next;
    logic       store;
    logic       starved;
    logic       if_resp;
    logic       dm_resp;

`ifdef MEM_ARB_STARVE_GUARD_EN
    mem_arb_starve_ctr #(
        .STARVE_MAX(STARVE_MAX)
    ) u_starve_ctr (
        .clk      (clk),
        .rst      (rst),
        .dm_grant (dm_gnt),
        .if_grant (if_gnt),
        .if_req   (if_req),
        .starved  (starved)
    );
`else
    assign starved = 1'b0;
`endif

    always_comb begin
        state_next  = state;
        killed_next = killed;
        sel         = OWN_IF;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_wstrb   = '0;
        if_gnt      = 1'b0;
        dm_gnt      = 1'b0;
        if_resp     = 1'b0;
        dm_resp     = 1'b0;
        if (rst) begin
            case (state)
                IDLE: begin
                    if (dm_req && !(starved && if_req)) begin
                        sel = OWN_DM;
                    end
                    mem_req = dm_req | if_req;
                    if (sel == OWN_DM) begin
                        mem_we    = dm_we;
                        mem_addr  = dm_addr;
                        mem_wdata = dm_wdata;
                        mem_wstrb = dm_wstrb;
                    end else if (if_req) begin
                        mem_addr  = if_addr;
                    end
                    if (mem_req && mem_ready) begin
                        if (sel == OWN_DM) begin
                            dm_gnt     = 1'b1;
                            state_next = BUSY_DM;
                        end else begin
                            if_gnt      = 1'b1;
                            state_next  = BUSY_IF;
                            killed_next = if_flush;
                        end
                    end
                end
                BUSY_IF: begin
                    // A flush arriving with the response still kills it.
                    if (mem_rvalid) begin
                        if_resp     = ~(killed | if_flush);
                        state_next  = IDLE;
                        killed_next = 1'b0;
                    end else if (if_flush) begin
                        killed_next = 1'b1;
                    end
                end
                BUSY_DM: begin
                    if (mem_rvalid) begin
                        dm_resp    = 1'b1;
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            killed    <= 1'b0;
            store     <= 1'b0;
            if_rvalid <= 1'b0;
            dm_rvalid <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            state     <= state_next;
            killed    <= killed_next;
            if_rvalid <= if_resp;
            dm_rvalid <= dm_resp;
            if (dm_gnt) begin
                store <= dm_we;
            end
            if (if_resp) begin
                if_rdata <= mem_rdata;
            end
            if (dm_resp) begin
                dm_rdata <= store ? '0 : mem_rdata;
            end
        end
    end

    assign if_stall = rst & if_req & ~if_gnt;
    // Data stall covers the whole access, even once the requester drops dm_req after its grant.
    assign dm_stall = rst & (dm_req | (state == BUSY_DM)) & ~dm_rvalid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a transaction-level reference model checked every cycle.
module tb_mem_port_arbiter;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_flush, if_gnt, if_rvalid, if_stall;
    logic [31:0] if_addr, if_rdata;
    logic        dm_req, dm_we, dm_gnt, dm_rvalid, dm_stall;
    logic [3:0]  dm_wstrb;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        mem_req, mem_we, mem_ready, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_flush   (if_flush),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .if_stall   (if_stall),
        .dm_req     (dm_req),
        .dm_we      (dm_we),
        .dm_wstrb   (dm_wstrb),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_gnt     (dm_gnt),
        .dm_rvalid  (dm_rvalid),
        .dm_rdata   (dm_rdata),
        .dm_stall   (dm_stall),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    int checks = 0;
    int errors = 0;

    function automatic void check1(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %b required %b at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void check32(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual 0x%08h required 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: one outstanding access, who owns it, whether its fetch was flushed,
    // and the response each requester must see one cycle after memory answers.
    bit          m_busy   = 1'b0;
    bit          m_own_dm = 1'b0;
    bit          m_killed = 1'b0;
    bit          m_store  = 1'b0;
    int          m_starve = 0;
    logic        m_if_rv  = 1'b0;
    logic        m_dm_rv  = 1'b0;
    logic [31:0] m_if_rd  = '0;
    logic [31:0] m_dm_rd  = '0;
    logic        chk_en   = 1'b0;

    function automatic bit pick_dm();
`ifdef MEM_ARB_STARVE_GUARD_EN
        return dm_req && !(if_req && (m_starve >= int'(STARVE_MAX)));
`else
        return dm_req;
`endif
    endfunction

    always @(posedge clk) begin : model_update
        bit take_dm;
        take_dm = pick_dm();
        m_if_rv = 1'b0;
        m_dm_rv = 1'b0;
        if (!rst) begin
            m_busy   = 1'b0;
            m_killed = 1'b0;
            m_store  = 1'b0;
            m_starve = 0;
            m_if_rd  = '0;
            m_dm_rd  = '0;
        end else begin
            if (m_busy) begin
                if (mem_rvalid) begin
                    if (m_own_dm) begin
                        m_dm_rv = 1'b1;
                        m_dm_rd = m_store ? 32'h0 : mem_rdata;
                    end else if (!m_killed && !if_flush) begin
                        m_if_rv = 1'b1;
                        m_if_rd = mem_rdata;
                    end
                    m_busy   = 1'b0;
                    m_killed = 1'b0;
                end else if (!m_own_dm && if_flush) begin
                    m_killed = 1'b1;
                end
            end else if (mem_ready && (dm_req || if_req)) begin
                m_busy   = 1'b1;
                m_own_dm = take_dm;
                if (take_dm) begin
                    m_store = dm_we;
                    if (if_req) m_starve++;
                end else begin
                    m_killed = if_flush;
                    m_starve = 0;
                end
            end
            if (!if_req) m_starve = 0;
        end
    end

    always @(negedge clk) begin : compare
        logic e_req, e_dm, e_if_gnt, e_dm_gnt;
        if (chk_en) begin
            e_req    = rst && !m_busy && (dm_req || if_req);
            e_dm     = pick_dm();
            e_dm_gnt = e_req && mem_ready && e_dm;
            e_if_gnt = e_req && mem_ready && !e_dm;
            check1("mem_req", mem_req, e_req);
            check1("if_gnt", if_gnt, e_if_gnt);
            check1("dm_gnt", dm_gnt, e_dm_gnt);
            if (e_req) begin
                check32("mem_addr", mem_addr, e_dm ? dm_addr : if_addr);
                check1("mem_we", mem_we, e_dm && dm_we);
                check32("mem_wstrb", {28'h0, mem_wstrb}, {28'h0, (e_dm ? dm_wstrb : 4'h0)});
                if (e_dm && dm_we) check32("mem_wdata", mem_wdata, dm_wdata);
            end
            check1("if_stall", if_stall, rst && if_req && !e_if_gnt);
            check1("dm_stall", dm_stall, rst && (dm_req || (m_busy && m_own_dm)) && !m_dm_rv);
            check1("if_rvalid", if_rvalid, m_if_rv);
            check1("dm_rvalid", dm_rvalid, m_dm_rv);
            if (m_if_rv) check32("if_rdata", if_rdata, m_if_rd);
            if (m_dm_rv) check32("dm_rdata", dm_rdata, m_dm_rd);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        if_req = 1'b1; if_addr = 32'h0000_0010; if_flush = 1'b0;
        dm_req = 1'b0; dm_we = 1'b0; dm_wstrb = 4'h0; dm_addr = '0; dm_wdata = '0;
        mem_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;

        // Reset held for two cycles with a pending fetch
        tick(); chk_en = 1'b1; #1;
        check1("rst_mem_req", mem_req, 1'b0);
        check1("rst_if_gnt", if_gnt, 1'b0);
        check1("rst_if_stall", if_stall, 1'b0);
        check1("rst_if_rvalid", if_rvalid, 1'b0);
        check32("rst_if_rdata", if_rdata, 32'h0);
        check32("rst_dm_rdata", dm_rdata, 32'h0);
        tick(); rst = 1'b1; mem_ready = 1'b0; #1;
        check1("rel_no_ready_gnt", if_gnt, 1'b0);
        check1("rel_if_stall", if_stall, 1'b1);
        tick(); mem_ready = 1'b1; #1;
        check1("rel_first_gnt", if_gnt, 1'b1);
        check32("rel_mem_addr", mem_addr, 32'h0000_0010);
        tick(); if_req = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0013;
        tick(); mem_rvalid = 1'b0;

        // Fetch with single-cycle memory latency
        tick(); if_req = 1'b1; if_addr = 32'h0000_0020; mem_ready = 1'b1; #1;
        check1("fetch_gnt_t", if_gnt, 1'b1);
        tick(); if_req = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0010_0093; #1;
        check1("fetch_rvalid_t1", if_rvalid, 1'b0);
        tick(); mem_rvalid = 1'b0; #1;
        check1("fetch_rvalid_t2", if_rvalid, 1'b1);
        check32("fetch_rdata_t2", if_rdata, 32'h0010_0093);
        tick(); #1;
        check1("fetch_rvalid_pulse", if_rvalid, 1'b0);

        // Contention: data load wins, fetch follows one cycle after the data response
        if_req = 1'b1; if_addr = 32'h0000_0024; dm_req = 1'b1; dm_we = 1'b0;
        dm_addr = 32'h0000_0100; dm_wstrb = 4'hF; mem_ready = 1'b1; #1;
        check1("cont_dm_gnt", dm_gnt, 1'b1);
        check1("cont_if_gnt0", if_gnt, 1'b0);
        check32("cont_mem_addr", mem_addr, 32'h0000_0100);
        tick(); dm_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_0001; #1;
        check1("cont_busy_no_req", mem_req, 1'b0);
        check1("cont_if_stall", if_stall, 1'b1);
        check1("cont_dm_stall", dm_stall, 1'b1);
        tick(); mem_rvalid = 1'b0; #1;
        check1("cont_if_gnt", if_gnt, 1'b1);
        check1("cont_dm_rvalid", dm_rvalid, 1'b1);
        check32("cont_dm_rdata", dm_rdata, 32'hCAFE_0001);
        tick(); if_req = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0011;
        tick(); mem_rvalid = 1'b0; #1;
        check32("cont_if_rdata", if_rdata, 32'h0000_0011);

        // Store with a two-cycle memory latency
        tick(); dm_req = 1'b1; dm_we = 1'b1; dm_wstrb = 4'b0011; dm_addr = 32'h0000_0200;
        dm_wdata = 32'hDEAD_BEEF; #1;
        check32("store_wstrb", {28'h0, mem_wstrb}, 32'h0000_0003);
        check1("store_stall_wait", dm_stall, 1'b1);
        tick(); mem_ready = 1'b1; #1;
        check1("store_gnt", dm_gnt, 1'b1);
        tick(); dm_req = 1'b0; mem_ready = 1'b0;
        tick(); mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678; #1;
        check1("store_stall_rvalid_cycle", dm_stall, 1'b1);
        tick(); mem_rvalid = 1'b0; #1;
        check1("store_dm_rvalid", dm_rvalid, 1'b1);
        check32("store_dm_rdata", dm_rdata, 32'h0);
        check1("store_stall_fall", dm_stall, 1'b0);

        // Flush while the fetch is outstanding, then a normal fetch
        tick(); if_req = 1'b1; if_addr = 32'h0000_0050; mem_ready = 1'b1;
        tick(); if_req = 1'b0; mem_ready = 1'b0; if_flush = 1'b1;
        tick(); if_flush = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_0001;
        tick(); mem_rvalid = 1'b0; #1;
        check1("flush_busy_suppressed", if_rvalid, 1'b0);
        if_req = 1'b1; if_addr = 32'h0000_0054; mem_ready = 1'b1; #1;
        check1("flush_next_gnt", if_gnt, 1'b1);
        tick(); if_req = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0020_0113;
        tick(); mem_rvalid = 1'b0; #1;
        check1("flush_next_rvalid", if_rvalid, 1'b1);
        check32("flush_next_rdata", if_rdata, 32'h0020_0113);

        // Flush coincident with the memory response
        tick(); if_req = 1'b1; if_addr = 32'h0000_0058; mem_ready = 1'b1;
        tick(); if_req = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b1; if_flush = 1'b1;
        mem_rdata = 32'hBAD0_0002;
        tick(); mem_rvalid = 1'b0; if_flush = 1'b0; #1;
        check1("flush_coincident_suppressed", if_rvalid, 1'b0);

        // Flush in the grant cycle
        tick(); if_req = 1'b1; if_addr = 32'h0000_005C; if_flush = 1'b1; mem_ready = 1'b1;
        tick(); if_req = 1'b0; if_flush = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b1;
        mem_rdata = 32'hBAD0_0003;
        tick(); mem_rvalid = 1'b0; #1;
        check1("flush_at_gnt_suppressed", if_rvalid, 1'b0);

        // Flush in IDLE with no grant is ignored
        tick(); if_req = 1'b1; if_addr = 32'h0000_0060; if_flush = 1'b1; #1;
        check1("flush_idle_no_gnt", if_gnt, 1'b0);
        tick(); if_flush = 1'b0; mem_ready = 1'b1;
        tick(); if_req = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0033;
        tick(); mem_rvalid = 1'b0; #1;
        check1("flush_idle_rvalid", if_rvalid, 1'b1);
        check32("flush_idle_rdata", if_rdata, 32'h0000_0033);

        // Spurious response in IDLE
        tick(); mem_rvalid = 1'b1; mem_rdata = 32'h0000_0077;
        tick(); mem_rvalid = 1'b0; #1;
        check1("spurious_if_rvalid", if_rvalid, 1'b0);
        check1("spurious_dm_rvalid", dm_rvalid, 1'b0);

        // Reset while a load is in flight drops its response
        tick(); dm_req = 1'b1; dm_we = 1'b0; dm_wstrb = 4'hF; dm_addr = 32'h0000_0400; mem_ready = 1'b1;
        tick(); dm_req = 1'b0; mem_ready = 1'b0; rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0099;
        tick(); rst = 1'b1; mem_rvalid = 1'b0; #1;
        check1("midrst_dm_rvalid", dm_rvalid, 1'b0);
        check32("midrst_if_rdata", if_rdata, 32'h0);
        check1("midrst_dm_stall", dm_stall, 1'b0);
        if_req = 1'b1; if_addr = 32'h0000_0070; mem_ready = 1'b1; #1;
        check1("midrst_idle_gnt", if_gnt, 1'b1);
        tick(); if_req = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0044;
        tick(); mem_rvalid = 1'b0;

        // Continuous data traffic against a waiting fetch
        tick(); dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0300; if_req = 1'b1;
        if_addr = 32'h0000_0080; mem_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            logic exp_if;
`ifdef MEM_ARB_STARVE_GUARD_EN
            exp_if = (k == 4);
`else
            exp_if = 1'b0;
`endif
            #1;
            check1($sformatf("starve_if_gnt%0d", k), if_gnt, exp_if);
            check1($sformatf("starve_dm_gnt%0d", k), dm_gnt, !exp_if);
            tick(); mem_rvalid = 1'b1; mem_rdata = 32'h0000_0100 + k;
            tick(); mem_rvalid = 1'b0;
        end
        dm_req = 1'b0; if_req = 1'b0; mem_ready = 1'b0;
        tick();
        tick();
        chk_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
